// File: rtl/unidad_busqueda.sv
// Instruction fetch stage: single-outstanding memory port feeding a small instruction FIFO.
// Define UNIDAD_BUSQUEDA_CONTADOR_EN to add cuenta_instr_o, a running count of consumed instructions.
module unidad_busqueda #(
  parameter int unsigned          ANCHO_DIR   = 32,
  parameter logic [ANCHO_DIR-1:0] PC_RESET    = '0,
  parameter int unsigned          PROFUNDIDAD = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 mem_req_o,
  output logic [ANCHO_DIR-1:0] mem_dir_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 salto_i,
  input  logic [ANCHO_DIR-1:0] destino_i,
  output logic                 valido_o,
  input  logic                 listo_i,
  output logic [31:0]          instruccion_o,
  output logic [ANCHO_DIR-1:0] pc_o
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
  ,
  output logic [31:0]          cuenta_instr_o
`endif
);

  localparam int unsigned PTR_W = $clog2(PROFUNDIDAD);
  localparam int unsigned OCU_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [ANCHO_DIR-1:0] pc_fetch_q, pc_fetch_d;
  logic [ANCHO_DIR-1:0] pc_pend_q, pc_pend_d;
  logic [ANCHO_DIR-1:0] pc_ult_q, pc_ult_d;
  logic                 pendiente_q, pendiente_d;
  logic                 descartar_q, descartar_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OCU_W-1:0]     ocupacion_q, ocupacion_d;

  logic [31:0]          fifo_instr_q [PROFUNDIDAD];
  logic [ANCHO_DIR-1:0] fifo_pc_q    [PROFUNDIDAD];

  logic aceptar, respuesta, push, pop;

  assign valido_o      = (ocupacion_q != '0);
  assign mem_dir_o     = pc_fetch_q;
  assign instruccion_o = valido_o ? fifo_instr_q[rd_ptr_q] : NOP;
  assign pc_o          = valido_o ? fifo_pc_q[rd_ptr_q] : pc_ult_q;

  // With nothing pending, the free-space test reduces to occupancy alone.
  assign mem_req_o = rst_ni && !pendiente_q && !salto_i &&
                     (ocupacion_q < OCU_W'(PROFUNDIDAD));
  assign aceptar   = mem_req_o && mem_ack_i;
  assign respuesta = mem_rvalid_i && pendiente_q;
  assign push      = respuesta && !descartar_q && !salto_i;
  assign pop       = valido_o && listo_i && !salto_i;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave it unassigned and infer a latch.
    pc_fetch_d  = pc_fetch_q;
    pc_pend_d   = pc_pend_q;
    pc_ult_d    = pc_ult_q;
    pendiente_d = pendiente_q;
    descartar_d = descartar_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    ocupacion_d = ocupacion_q;

    if (salto_i) begin
      pc_fetch_d  = destino_i & ~ANCHO_DIR'(3);
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      ocupacion_d = '0;
      // A response landing this cycle is dropped outright; otherwise remember to drop it later.
      pendiente_d = pendiente_q && !mem_rvalid_i;
      descartar_d = pendiente_q && !mem_rvalid_i;
    end else begin
      if (aceptar) begin
        pendiente_d = 1'b1;
        pc_pend_d   = pc_fetch_q;
        pc_fetch_d  = pc_fetch_q + ANCHO_DIR'(4);
      end
      if (respuesta) begin
        pendiente_d = 1'b0;
        descartar_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        pc_ult_d = fifo_pc_q[rd_ptr_q];
      end
      ocupacion_d = ocupacion_q + OCU_W'(push) - OCU_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_fetch_q  <= PC_RESET;
      pc_pend_q   <= PC_RESET;
      pc_ult_q    <= PC_RESET;
      pendiente_q <= 1'b0;
      descartar_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      ocupacion_q <= '0;
    end else begin
      pc_fetch_q  <= pc_fetch_d;
      pc_pend_q   <= pc_pend_d;
      pc_ult_q    <= pc_ult_d;
      pendiente_q <= pendiente_d;
      descartar_q <= descartar_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      ocupacion_q <= ocupacion_d;
    end
  end

  // NOTE: FIFO storage has no reset; valido_o masks every slot until a word has been written into it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= mem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= pc_pend_q;
    end
  end

`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
  logic [31:0] cuenta_q, cuenta_d;

  assign cuenta_d       = cuenta_q + 32'(pop);
  assign cuenta_instr_o = cuenta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cuenta_q <= '0;
    else         cuenta_q <= cuenta_d;
  end
`endif

endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
Instruction fetch stage of the monocycle RISC-V core. It sits directly upstream of the decoder and immediate-extension logic, and supplies the 32-bit instruction word and its PC to them. It owns the fetch PC, issues requests to instruction memory over a valid/ready interface, and buffers returned words in a small FIFO. Branch/jump redirects flush any stale words.

Parameters:
ANCHO_DIR, 32, address width in bits.
PC_RESET, 32'h0000_0000, fetch address after reset.
PROFUNDIDAD, 2, instruction FIFO depth; power of two, minimum 2.

Ports:
clk_i  input  1  core clock; all state updates on rising edge.
rst_ni  input  1  asynchronous active-low reset.
mem_req_o  output  1  fetch request valid.
mem_dir_o  output  ANCHO_DIR  fetch address; word aligned.
mem_ack_i  input  1  memory accepts request; transfer when mem_req_o && mem_ack_i.
mem_rvalid_i  input  1  read data valid; exactly one per accepted request, in order, at least 1 cycle after accept.
mem_rdata_i  input  32  instruction word.
salto_i  input  1  redirect strobe from execute (taken branch/jump).
destino_i  input  ANCHO_DIR  redirect target; bits [1:0] forced to 0.
valido_o  output  1  instruccion_o/pc_o hold a valid instruction.
listo_i  input  1  downstream consumes the head when valido_o && listo_i.
instruccion_o  output  32  head instruction; 32'h0000_0013 (NOP) when FIFO empty.
pc_o  output  ANCHO_DIR  PC of head instruction; last popped PC when empty.

Behaviour:
- Reset values (async, rst_ni=0): fetch PC=PC_RESET, mem_req_o=0, mem_dir_o=PC_RESET, valido_o=0, instruccion_o=32'h00000013, pc_o=PC_RESET, FIFO empty, pendiente=0, descartar=0.
- Single outstanding request. mem_req_o=1 when pendiente=0 and ocupacion+pendiente < PROFUNDIDAD, with no salto_i in the same cycle. mem_dir_o = fetch PC.
- Memory may drop mem_ack_i at any time. The block may withdraw or change mem_req_o/mem_dir_o only on redirect.
- On accept: pendiente<=1, fetch PC<=fetch PC+4 (wraps modulo 2^ANCHO_DIR).
- On mem_rvalid_i with pendiente=1: pendiente<=0. If descartar=0, push {mem_rdata_i, PC of request}; if descartar=1, drop the word and clear descartar.
- mem_rvalid_i with pendiente=0 is ignored.
- valido_o = FIFO not empty. Outputs are driven registered from the FIFO head. Pop on valido_o && listo_i. Push and pop in the same cycle are allowed at any occupancy below full.
- Redirect (salto_i=1), which has highest priority:
  - FIFO cleared next cycle (valido_o=0).
  - fetch PC<=destino_i & ~3.
  - mem_req_o forced 0 this cycle.
  - If a request is pending, or a response arrives this same cycle, that response is dropped; descartar<=1 if the response is still outstanding.
  - Any pop in the same cycle is ignored.
- Back-to-back redirects: the last one wins. At most one response is ever discarded.
- Latency: with zero-wait memory (ack same cycle, rvalid next cycle), the first valido_o rises 2 cycles after reset release. Steady-state throughput is 1 instruction per 2 cycles; the memory is expected to pipeline via the FIFO in later revisions.
- FIFO full: no new request, and words already in the FIFO are held.
- Reset mid-transaction: all state cleared. A later stray mem_rvalid_i is ignored (pendiente=0).

Optional Feature:
UNIDAD_BUSQUEDA_CONTADOR_EN. When defined, adds output cuenta_instr_o [31:0]: the count of instructions popped (valido_o && listo_i && !salto_i). It resets to 0 and wraps at 2^32. When undefined, the port and counter do not exist and the remaining behaviour is identical.

Test Plan:
- Reset release, zero-wait memory returning 0x00500093 at address 0 -> mem_dir_o=0; valido_o=1 two cycles later with instruccion_o=0x00500093, pc_o=0; next request address 4.
- listo_i held 0 with PROFUNDIDAD=2 -> exactly 2 words buffered (PC 0, 4); mem_req_o stays 0; head stable until listo_i=1.
- mem_ack_i delayed 3 cycles -> mem_req_o and mem_dir_o stay stable; a single accept; fetch PC advances by 4 only once.
- salto_i with destino_i=0x103 while a response is outstanding -> FIFO empty next cycle; the outstanding word is discarded; next request address 0x100; first valid pc_o=0x100.
- Redirect coincident with mem_rvalid_i and a pop -> word dropped, no pop effect, descartar=0, next fetch at target.
- rst_ni pulsed low mid-request, then a stray mem_rvalid_i -> outputs return to reset values; the stray response is ignored; fetch restarts at PC_RESET.
